// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate format codes for the immediate-generation stage.
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

    // SLLI/SRLI/SRAI live under OP_IMM with funct3 001/101.
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instruction word -> extended immediate, format, illegal flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    fmt_e       fmt_sel;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign fmt    = fmt_sel;

    always_comb begin
        imm     = '0;
        fmt_sel = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (is_shift_funct3(funct3)) begin
                    fmt_sel = FMT_SH;
                    // RV32 has only a 5-bit shamt; bit 25 set is a malformed encoding.
                    if (XLEN == 32 && instr[25]) begin
                        illegal = 1'b1;
                    end else begin
                        imm = XLEN'(instr[20 +: SHAMT_W]);
                    end
                end else begin
                    fmt_sel = FMT_I;
                    imm     = XLEN'($signed(instr[31:20]));
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt_sel = FMT_I;
                imm     = XLEN'($signed(instr[31:20]));
            end
            OP_STORE: begin
                fmt_sel = FMT_S;
                imm     = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                fmt_sel = FMT_B;
                imm     = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                fmt_sel = FMT_U;
                imm     = XLEN'($signed({instr[31:12], 12'h000}));
            end
            OP_JAL: begin
                fmt_sel = FMT_J;
                imm     = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21],
                                         1'b0}));
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    fmt_sel = FMT_Z;
                    imm     = XLEN'(instr[19:15]);
                end
            end
            default: begin
                imm     = '0;
                fmt_sel = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode + PC-relative adder behind a 2-entry skid buffer.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t EntryReset = '{imm: '0, target: '0, fmt: FMT_NONE, illegal: 1'b0};

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   in_fire, main_free;

    imm_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_entry = '{imm: dec_imm, target: in_pc + dec_imm, fmt: dec_fmt,
                        illegal: dec_illegal};

    // Ready depends only on skid occupancy, so no combinational path from out_ready.
    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign main_free = !main_valid_q || out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            // A full skid implies in_ready=0, so skid and input never compete here.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= EntryReset;
            skid_q       <= EntryReset;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: XLEN=32 and XLEN=64 stages share one stimulus stream, checked against a model.
module tb_imm_gen_stage;
    import imm_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] target;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy32, val32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, val64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    int n_total = 0;
    int n_pass  = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (rdy32), .in_instr (in_instr), .in_pc (in_pc[31:0]),
        .out_valid (val32), .out_ready (out_ready), .out_imm (imm32), .out_fmt (fmt32),
        .out_target (tgt32), .out_illegal (ill32)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (rdy64), .in_instr (in_instr), .in_pc (in_pc),
        .out_valid (val64), .out_ready (out_ready), .out_imm (imm64), .out_fmt (fmt64),
        .out_target (tgt64), .out_illegal (ill64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout/unexpected expected normal progress", name);
    endtask

    // Reference: immediates from the ISA field rules using plain signed arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        exp_t        e;
        longint      s, v;
        logic [63:0] mask;
        s     = longint'($signed(ins));
        v     = 0;
        e.fmt = FMT_NONE;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h13: begin
                if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
                    e.fmt = FMT_SH;
                    if (xlen == 32 && ins[25]) e.ill = 1'b1;
                    else v = longint'(ins >> 20) & longint'(xlen - 1);
                end else begin
                    e.fmt = FMT_I;
                    v     = s >>> 20;
                end
            end
            7'h03, 7'h67: begin e.fmt = FMT_I; v = s >>> 20; end
            7'h23: begin
                e.fmt = FMT_S;
                v     = (s >>> 25) * 32 + longint'((ins >> 7) & 32'h1F);
            end
            7'h63: begin
                e.fmt = FMT_B;
                v = (s >>> 31) * 4096 + longint'((ins >> 7) & 1) * 2048
                  + longint'((ins >> 25) & 32'h3F) * 32 + longint'((ins >> 8) & 32'hF) * 2;
            end
            7'h37, 7'h17: begin e.fmt = FMT_U; v = s & ~longint'(32'hFFF); end
            7'h6F: begin
                e.fmt = FMT_J;
                v = (s >>> 31) * 1048576 + longint'((ins >> 12) & 32'hFF) * 4096
                  + longint'((ins >> 20) & 1) * 2048 + longint'((ins >> 21) & 32'h3FF) * 2;
            end
            7'h73: if (ins[14]) begin e.fmt = FMT_Z; v = longint'((ins >> 15) & 32'h1F); end
            default: v = 0;
        endcase
        mask     = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.imm    = 64'(v) & mask;
        e.target = (pc + 64'(v)) & mask;
        return e;
    endfunction

    // Stimulus side of the scoreboard: record every accepted input.
    always @(negedge clk) begin
        if (rst_n && in_valid && rdy32 && !flush) begin
            q32.push_back(model(in_instr, in_pc, 32));
            q64.push_back(model(in_instr, in_pc, 64));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready_match", {63'h0, rdy64}, {63'h0, rdy32});
            if (val32 && out_ready) begin
                if (q32.size() == 0) fail_now("out32_unexpected");
                else begin
                    e = q32.pop_front();
                    chk("imm32", {32'h0, imm32}, e.imm);
                    chk("tgt32", {32'h0, tgt32}, e.target);
                    chk("fmt32", {61'h0, fmt32}, {61'h0, e.fmt});
                    chk("ill32", {63'h0, ill32}, {63'h0, e.ill});
                end
            end
            if (flush) q32.delete();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (val64 && out_ready) begin
                if (q64.size() == 0) fail_now("out64_unexpected");
                else begin
                    e = q64.pop_front();
                    chk("imm64", imm64, e.imm);
                    chk("tgt64", tgt64, e.target);
                    chk("fmt64", {61'h0, fmt64}, {61'h0, e.fmt});
                    chk("ill64", {63'h0, ill64}, {63'h0, e.ill});
                end
            end
            if (flush) q64.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        logic acc;
        int   t;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        acc      = 1'b0;
        t        = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = rdy32 && !flush;
            step();
            t++;
        end
        if (!acc) fail_now("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while ((q32.size() != 0 || q64.size() != 0 || val32) && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) fail_now("drain_timeout");
        step();
    endtask

    task automatic fill_both();
        out_ready = 1'b0;
        send(32'h0000_0513, 64'h10);
        send(32'h0040_0593, 64'h20);
    endtask

    logic  rand_done;
    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};

    initial begin
        logic [31:0] r;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        in_pc     = '0;
        rst_n     = 1'b0;
        #12;
        chk("rst_valid", {62'h0, val32, val64}, 64'h0);
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_tgt32", {32'h0, tgt32}, 64'h0);
        chk("rst_fmt", {58'h0, fmt32, fmt64}, 64'h0);
        chk("rst_ill", {62'h0, ill32, ill64}, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {63'h0, rdy32}, 64'h1);

        // Directed vectors: first one also checks single-cycle latency into an empty stage.
        send(32'hFFF0_0093, 64'h0);
        chk("latency1", {63'h0, val32}, 64'h1);
        send(32'h1234_5037, 64'h0);
        send(32'h8000_0037, 64'h0);
        send(32'h0080_006F, 64'h100);
        send(32'hFE00_0EE3, 64'h200);
        send(32'h0200_1093, 64'h0);
        send(32'h0007_D073, 64'h40);
        send(32'hFE11_2E23, 64'h80);
        send(32'h0000_0033, 64'h0);
        drain();

        // Backpressure: two accepts fill main+skid, the third must wait.
        out_ready = 1'b0;
        send(32'h0010_0093, 64'h1000);
        send(32'h0020_0113, 64'h1004);
        in_valid = 1'b1;
        in_instr = 32'h0030_0193;
        in_pc    = 64'h1008;
        @(negedge clk);
        chk("bp_in_ready_low", {63'h0, rdy32}, 64'h0);
        step();
        step();
        out_ready = 1'b1;
        send(32'h0030_0193, 64'h1008);
        send(32'h0040_0213, 64'h100C);
        drain();

        // Flush with both entries full, while a new input is offered.
        fill_both();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h7FF0_0093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {62'h0, val32, val64}, 64'h0);
        chk("flush_in_ready", {63'h0, rdy32}, 64'h1);

        // Flush with output draining and in_ready=1: delivered head counts, offered input dropped.
        out_ready = 1'b0;
        send(32'h0050_0293, 64'h30);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0060_0313;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            chk("flush_no_ghost", {63'h0, val32}, 64'h0);
            step();
        end

        // Asynchronous reset mid-cycle with both entries full.
        fill_both();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {62'h0, val32, val64}, 64'h0);
        q32.delete();
        q64.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {63'h0, rdy32}, 64'h1);

        // Random traffic with random backpressure and sparse flushes.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    r = $urandom();
                    send({r[31:7], ops[$urandom_range(0, 9)]}, {$urandom(), $urandom()});
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step();
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush     = ($urandom_range(0, 59) == 0);
                end
                flush = 1'b0;
            end
        join
        drain();
        chk("final_q32_empty", 64'(q32.size()), 64'h0);
        chk("final_q64_empty", 64'(q64.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
